// File: rtl/irq_requester.sv
// Interrupt requester: sticky pending/overrun per source, mask, and a one-at-a-time
// 4-phase req/ack handshake. Define IRQ_TIMEOUT_EN to add the ack-wait timeout with round-robin retry.

module irq_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic event_in,
  input  logic ack_clr,
  input  logic ovr_clr,
  output logic pending,
  output logic overrun
);
  // A new event always wins over the acknowledge clear and over the overrun clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pending <= event_in | (pending & ~ack_clr);
      overrun <= (event_in & pending & ~ack_clr) | (overrun & ~ovr_clr);
    end
  end
endmodule

module irq_requester #(
  parameter int NUM_SRC     = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] event_in,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic [NUM_SRC-1:0] ovr_clr,
  input  logic               irq_ack,
  output logic [NUM_SRC-1:0] irq_req,
  output logic [4:0]         irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overrun,
  output logic               busy,
  output logic               timeout_flag
);
  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  if (NUM_SRC < 2 || NUM_SRC > 32 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("irq_requester: NUM_SRC must be 2..32 and TIMEOUT_CYC >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] sel_onehot;
  logic [IDW-1:0]     sel_id;
  logic [IDW-1:0]     arb_start;
  logic               sel_vld;

  // irq_req is one-hot in REQ, so it doubles as the per-source clear vector.
  assign ack_clr  = (state == S_REQ && irq_ack) ? irq_req : '0;
  assign eligible = pending & ~mask;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_src_cell u_cell (
      .clk      (clk),
      .reset    (reset),
      .event_in (event_in[i]),
      .ack_clr  (ack_clr[i]),
      .ovr_clr  (ovr_clr[i]),
      .pending  (pending[i]),
      .overrun  (overrun[i])
    );
  end

`ifdef IRQ_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0]  cnt;
  logic           rr_active;
  logic [IDW-1:0] rr_start;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] next_id;
  logic           tflag;

  assign cur_id       = irq_id[IDW-1:0];
  assign next_id      = (cur_id == IDW'(NUM_SRC - 1)) ? '0 : cur_id + IDW'(1);
  assign arb_start    = rr_active ? rr_start : '0;
  assign timeout_flag = tflag;
`else
  assign arb_start    = '0;
  assign timeout_flag = 1'b0;
`endif

  // Circular priority search from arb_start; arb_start is 0 except right after a timeout.
  always_comb begin
    int idx;
    idx     = 0;
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = int'(arb_start) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!sel_vld && eligible[idx]) begin
        sel_vld = 1'b1;
        sel_id  = idx[IDW-1:0];
      end
    end
  end

  assign sel_onehot = {{(NUM_SRC-1){1'b0}}, 1'b1} << sel_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      mask    <= '1;
      irq_req <= '0;
      irq_id  <= '0;
      busy    <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
      cnt       <= '0;
      rr_active <= 1'b0;
      rr_start  <= '0;
      tflag     <= 1'b0;
`endif
    end else begin
      if (mask_wr) mask <= mask_wdata;
      case (state)
        S_IDLE: begin
          if (sel_vld) begin
            irq_id  <= 5'(sel_id);
            irq_req <= sel_onehot;
            busy    <= 1'b1;
            state   <= S_REQ;
`ifdef IRQ_TIMEOUT_EN
            cnt       <= '0;
            rr_active <= 1'b0;
`endif
          end
        end
        S_REQ: begin
          if (irq_ack) begin
            irq_req <= '0;
            state   <= S_RELEASE;
          end
`ifdef IRQ_TIMEOUT_EN
          // Give up on a dead controller path; pending stays so the source is retried later.
          else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            irq_req   <= '0;
            busy      <= 1'b0;
            tflag     <= 1'b1;
            rr_active <= 1'b1;
            rr_start  <= next_id;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        S_RELEASE: begin
          if (!irq_ack) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
